// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART program loader driving the instruction-memory write port
module imem_uart_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]    MAX_N   = 16'(MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} fr_state_t;

  rx_state_t rx_state, rx_next;
  fr_state_t fr_state, fr_next;

  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_byte;
  logic          rx_tick;
  logic          byte_valid, frame_err;

  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   len_rx;
  logic [15:0]   word_cnt;
  logic [1:0]    byte_idx;
  logic [7:0]    acc;

  // Two-flop synchronizer plus a delayed copy for start-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Byte receiver state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  // Byte receiver next state; the start bit is probed at mid-bit, later bits one bit period apart
  always_comb begin
    rx_next = rx_state;
    rx_tick = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
      RX_START: if (rx_cnt == HALF_M1) begin
                  rx_tick = 1'b1;
                  rx_next = rx_s2 ? RX_IDLE : RX_DATA;
                end
      RX_DATA:  if (rx_cnt == FULL_M1) begin
                  rx_tick = 1'b1;
                  if (bit_cnt == 3'd7) rx_next = RX_STOP;
                end
      RX_STOP:  if (rx_cnt == FULL_M1) begin
                  rx_tick = 1'b1;
                  rx_next = RX_IDLE;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Byte receiver datapath: bit timer, LSB-first shift register, one-cycle result strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt     <= '0;
      bit_cnt    <= 3'd0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + CW'(1);
      if (rx_state == RX_START) bit_cnt <= 3'd0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_byte <= {rx_s2, rx_byte[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (rx_state == RX_STOP && rx_tick) begin
        byte_valid <= rx_s2;
        frame_err  <= !rx_s2;
      end
    end
  end

  assign len_rx = {rx_byte, len_lo};

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fr_state <= IDLE;
    else      fr_state <= fr_next;
  end

  // Frame FSM next state; framing errors only matter once a frame has started
  always_comb begin
    fr_next = fr_state;
    case (fr_state)
      IDLE: if (byte_valid && rx_byte == 8'hA5) fr_next = LEN0;
      LEN0: if (frame_err) fr_next = ERR;
            else if (byte_valid) fr_next = LEN1;
      LEN1: if (frame_err) fr_next = ERR;
            else if (byte_valid) begin
              if (len_rx > MAX_N)       fr_next = ERR;
              else if (len_rx == 16'd0) fr_next = CSUM;
              else                      fr_next = DATA;
            end
      DATA: if (frame_err) fr_next = ERR;
            else if (byte_valid && byte_idx == 2'd3 && word_cnt == len - 16'd1) fr_next = CSUM;
      CSUM: if (frame_err) fr_next = ERR;
            else if (byte_valid) fr_next = (rx_byte == acc) ? DONE : ERR;
      DONE:    fr_next = IDLE;
      ERR:     fr_next = IDLE;
      default: fr_next = IDLE;
    endcase
  end

  // Frame datapath: length capture, checksum, word assembly, write strobe and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= 32'h0;
      wr_data   <= 32'h0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len_lo    <= 8'h00;
      len       <= 16'h0;
      word_cnt  <= 16'h0;
      byte_idx  <= 2'd0;
      acc       <= 8'h00;
    end else begin
      wr_en <= 1'b0;
      if (wr_en) wr_addr <= wr_addr + 32'd4;
      case (fr_state)
        IDLE: if (byte_valid && rx_byte == 8'hA5) begin
                cpu_hold  <= 1'b1;
                load_done <= 1'b0;
                load_err  <= 1'b0;
                acc       <= 8'h00;
                wr_addr   <= BASE_ADDR;
                word_cnt  <= 16'h0;
                byte_idx  <= 2'd0;
              end
        LEN0: if (byte_valid) begin
                len_lo <= rx_byte;
                acc    <= acc ^ rx_byte;
              end
        LEN1: if (byte_valid) begin
                len <= len_rx;
                acc <= acc ^ rx_byte;
              end
        DATA: if (byte_valid) begin
                acc      <= acc ^ rx_byte;
                wr_data  <= {rx_byte, wr_data[31:8]};
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  wr_en    <= 1'b1;
                  word_cnt <= word_cnt + 16'd1;
                end
              end
        default: ;
      endcase
      if (fr_next == DONE) begin
        load_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end
      if (fr_next == ERR) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - table-driven bench for imem_uart_loader
module tb_imem_uart_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] bytes;
    logic [3:0]  n;
    logic [3:0]  bad;
    logic [1:0]  nwr;
    logic [31:0] a0, d0, a1, d1;
    logic        done, err, hold;
  } vec_t;

  vec_t        tv [5];
  int          n_checks = 0;
  int          n_err = 0;
  int          wcnt = 0;
  logic [31:0] wa [8];
  logic [31:0] wd [8];
  int          lat;

  // Record every write strobe seen away from the active edge
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wcnt < 8) begin
        wa[wcnt] = wr_addr;
        wd[wcnt] = wr_data;
      end
      wcnt = wcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [95:0] b, input int n, input int bad);
    for (int i = 0; i < n; i++) send_byte(b[95-8*i -: 8], i != bad);
  endtask

  initial begin
    tv[0] = '{bytes: 96'hA502_0013_0470_0093_0450_00A2, n: 4'd12, bad: 4'd15, nwr: 2'd2,
              a0: 32'h0, d0: 32'h0070_0413, a1: 32'h4, d1: 32'h0050_0493,
              done: 1'b1, err: 1'b0, hold: 1'b0};
    tv[1] = '{bytes: 96'hA502_0013_0470_0093_0450_00A3, n: 4'd12, bad: 4'd15, nwr: 2'd2,
              a0: 32'h0, d0: 32'h0070_0413, a1: 32'h4, d1: 32'h0050_0493,
              done: 1'b0, err: 1'b1, hold: 1'b1};
    tv[2] = '{bytes: {56'h00FF_5AA5_0000_00, 40'h0}, n: 4'd7, bad: 4'd15, nwr: 2'd0,
              a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0,
              done: 1'b1, err: 1'b0, hold: 1'b0};
    tv[3] = '{bytes: {32'hA501_0011, 64'h0}, n: 4'd4, bad: 4'd3, nwr: 2'd0,
              a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0,
              done: 1'b0, err: 1'b1, hold: 1'b1};
    tv[4] = '{bytes: {24'hA5_0101, 72'h0}, n: 4'd3, bad: 4'd15, nwr: 2'd0,
              a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0,
              done: 1'b0, err: 1'b1, hold: 1'b1};

    rx  = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", {31'b0, wr_en}, 32'h0);
    chk("reset_wr_addr", wr_addr, 32'h0);
    chk("reset_wr_data", wr_data, 32'h0);
    chk("reset_flags", {29'b0, cpu_hold, load_done, load_err}, 32'h0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      wcnt = 0;
      send_frame(tv[v].bytes, int'(tv[v].n), int'(tv[v].bad));
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_wr_count", v), 32'(wcnt), 32'(tv[v].nwr));
      if (tv[v].nwr > 0) begin
        chk($sformatf("v%0d_addr0", v), wa[0], tv[v].a0);
        chk($sformatf("v%0d_data0", v), wd[0], tv[v].d0);
        chk($sformatf("v%0d_addr1", v), wa[1], tv[v].a1);
        chk($sformatf("v%0d_data1", v), wd[1], tv[v].d1);
      end
      chk($sformatf("v%0d_load_done", v), {31'b0, load_done}, {31'b0, tv[v].done});
      chk($sformatf("v%0d_load_err", v), {31'b0, load_err}, {31'b0, tv[v].err});
      chk($sformatf("v%0d_cpu_hold", v), {31'b0, cpu_hold}, {31'b0, tv[v].hold});
      repeat (20) @(posedge clk);
      #1;
    end

    wcnt = 0;
    send_frame(96'hA502_0013_0470_0093_0400_0000, 9, 15);
    repeat (2) @(posedge clk);
    #1;
    chk("midload_wr_count", 32'(wcnt), 32'd1);
    chk("midload_addr0", wa[0], 32'h0);
    chk("midload_hold", {31'b0, cpu_hold}, 32'h1);
    rst = 1'b0;
    #1;
    chk("async_rst_hold", {31'b0, cpu_hold}, 32'h0);
    chk("async_rst_addr", wr_addr, 32'h0);
    chk("async_rst_data", wr_data, 32'h0);
    chk("async_rst_flags", {30'b0, load_done, load_err}, 32'h0);
    #20;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    wcnt = 0;
    send_frame(96'hA502_0013_0470_0093_0450_0000, 11, 15);
    chk("reload_hold_during", {31'b0, cpu_hold}, 32'h1);
    send_byte(8'hA2, 1'b1);
    @(negedge clk);
    lat = 1;
    while (cpu_hold !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_fall_latency_ok", {31'b0, (lat >= 1 && lat <= 4)}, 32'h1);
    chk("done_with_hold_fall", {31'b0, load_done}, 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reload_wr_count", 32'(wcnt), 32'd2);
    chk("reload_addr0", wa[0], 32'h0);
    chk("reload_data0", wd[0], 32'h0070_0413);
    chk("reload_addr1", wa[1], 32'h4);
    chk("reload_data1", wd[1], 32'h0050_0493);
    chk("reload_err", {31'b0, load_err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
